// File: rtl/multdiv_stall_controller.sv
// rtl/multdiv_stall_controller.sv - iterative signed mul/div sequencer that stalls the front end while it runs
//
// Detects mul/div in D/X, captures the bypassed operands, stalls for 33 cycles,
// then presents the result with an exception flag/code for one cycle.
//
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   DX_Latch_Instr            - D/X instruction (opcode [31:27], rd [26:22], ALU op [6:2])
//   DX_flush                  - D/X instruction squashed this cycle
//   operand_A, operand_B      - post-bypass rs / rt values, sampled only on the start edge
//   multdiv_stall             - hold PC, F/D, D/X and inject a nop into X/M
//   multdiv_result_ready      - select multdiv_result into X/M this cycle
//   multdiv_result            - low product word or quotient
//   multdiv_exception         - completing instruction writes r30 instead of rd
//   multdiv_exception_code    - 4 mul overflow, 5 divide by zero, 0 otherwise
//   multdiv_rd                - destination register of the instruction in flight
module multdiv_stall_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      DX_Latch_Instr,
    input  logic             DX_flush,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic             multdiv_stall,
    output logic             multdiv_result_ready,
    output logic [WIDTH-1:0] multdiv_result,
    output logic             multdiv_exception,
    output logic [31:0]      multdiv_exception_code,
    output logic [4:0]       multdiv_rd
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [4:0]       count;
    logic             is_div, neg_q, b_zero, exc;
    logic [4:0]       rd;
    logic [WIDTH:0]   acc, acc_n, addend, sum, shifted, diff;
    logic [WIDTH-1:0] lo, lo_n, mcand, quot, result;
    logic             qm1, qm1_n, mul_ovf;
    logic [2*WIDTH-1:0] product;

    logic [4:0] opcode, alu_op;
    logic       is_mul_op, is_div_op, start;
    logic       unused_instr_bits;

    assign opcode    = DX_Latch_Instr[31:27];
    assign alu_op    = DX_Latch_Instr[6:2];
    assign is_mul_op = (alu_op == 5'b00110);
    assign is_div_op = (alu_op == 5'b00111);
    // Reset wins over a start in the same cycle, so stall stays low while reset is held.
    assign start = (state == IDLE) && !reset && !DX_flush && (opcode == 5'd0)
                   && (is_mul_op || is_div_op);
    assign unused_instr_bits = ^{DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next           = state;
        multdiv_stall        = 1'b0;
        multdiv_result_ready = 1'b0;
        case (state)
            IDLE: begin
                multdiv_stall = start;
                if (start) state_next = RUN;
            end
            RUN: begin
                multdiv_stall = 1'b1;
                if (DX_flush)              state_next = IDLE;
                else if (count == 5'd31)   state_next = DONE;
            end
            DONE: begin
                multdiv_result_ready = !DX_flush;
                state_next           = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration of either algorithm. Multiply: Booth on {acc, lo, qm1} with a
    // 33-bit accumulator so that subtracting the most negative multiplicand cannot wrap.
    // Divide: restoring division, acc is the partial remainder, lo shifts dividend out
    // and quotient bits in.
    always_comb begin
        addend = '0;
        case ({lo[0], qm1})
            2'b01:   addend = {mcand[WIDTH-1], mcand};
            2'b10:   addend = -{mcand[WIDTH-1], mcand};
            default: addend = '0;
        endcase
        sum     = acc + addend;
        shifted = {acc[WIDTH-1:0], lo[WIDTH-1]};
        diff    = shifted - {1'b0, mcand};
        if (!is_div) begin
            acc_n = {sum[WIDTH], sum[WIDTH:1]};
            lo_n  = {sum[0], lo[WIDTH-1:1]};
            qm1_n = lo[0];
        end else begin
            qm1_n = qm1;
            if (!diff[WIDTH]) begin
                acc_n = diff;
                lo_n  = {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted;
                lo_n  = {lo[WIDTH-2:0], 1'b0};
            end
        end
        product = {acc_n[WIDTH-1:0], lo_n};
        mul_ovf = !((&product[2*WIDTH-1:WIDTH-1]) || ~(|product[2*WIDTH-1:WIDTH-1]));
        quot    = neg_q ? -lo_n : lo_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            acc    <= '0;
            lo     <= '0;
            qm1    <= 1'b0;
            mcand  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            b_zero <= 1'b0;
            rd     <= '0;
            result <= '0;
            exc    <= 1'b0;
        end else if (start) begin
            count  <= '0;
            acc    <= '0;
            qm1    <= 1'b0;
            is_div <= is_div_op;
            rd     <= DX_Latch_Instr[26:22];
            neg_q  <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
            b_zero <= (operand_B == '0);
            if (is_div_op) begin
                lo    <= operand_A[WIDTH-1] ? -operand_A : operand_A;
                mcand <= operand_B[WIDTH-1] ? -operand_B : operand_B;
            end else begin
                lo    <= operand_B;
                mcand <= operand_A;
            end
        end else if (state == RUN) begin
            acc   <= acc_n;
            lo    <= lo_n;
            qm1   <= qm1_n;
            count <= count + 5'd1;
            if (count == 5'd31 && !DX_flush) begin
                if (is_div) begin
                    result <= b_zero ? '0 : quot;
                    exc    <= b_zero;
                end else begin
                    result <= product[WIDTH-1:0];
                    exc    <= mul_ovf;
                end
            end
        end
    end

    assign multdiv_result         = result;
    assign multdiv_rd             = rd;
    assign multdiv_exception      = multdiv_result_ready && exc;
    assign multdiv_exception_code = !multdiv_exception ? 32'd0 : (is_div ? 32'd5 : 32'd4);

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// tb/tb_multdiv_stall_controller.sv - self-checking bench for multdiv_stall_controller
module tb_multdiv_stall_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] DX_Latch_Instr;
    logic        DX_flush;
    logic [31:0] operand_A, operand_B;
    logic        multdiv_stall, multdiv_result_ready, multdiv_exception;
    logic [31:0] multdiv_result, multdiv_exception_code;
    logic [4:0]  multdiv_rd;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    multdiv_stall_controller #(.WIDTH(32)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .DX_Latch_Instr         (DX_Latch_Instr),
        .DX_flush               (DX_flush),
        .operand_A              (operand_A),
        .operand_B              (operand_B),
        .multdiv_stall          (multdiv_stall),
        .multdiv_result_ready   (multdiv_result_ready),
        .multdiv_result         (multdiv_result),
        .multdiv_exception      (multdiv_exception),
        .multdiv_exception_code (multdiv_exception_code),
        .multdiv_rd             (multdiv_rd)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input bit is_div, input logic [4:0] rd);
        logic [14:0] mid;
        mid = 15'($urandom);
        return {5'd0, rd, mid, (is_div ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    // Reference: plain 64-bit signed arithmetic.
    task automatic model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output logic [31:0] c);
        longint sa, sb, p, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
            c = e ? 32'd4 : 32'd0;
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
            c = 32'd5;
        end else begin
            q = sa / sb;
            r = q[31:0];
            e = 1'b0;
            c = 32'd0;
        end
    endtask

    // Entered at cycle 0 (just after an edge); leaves just after the edge ending cycle 33.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        logic [31:0] er, ec;
        logic        ee;
        model(is_div, a, b, er, ee, ec);
        DX_Latch_Instr = mk(is_div, rd);
        operand_A      = a;
        operand_B      = b;
        DX_flush       = 1'b0;
        #3;
        check("stall_c0", 64'(multdiv_stall), 64'd1);
        check("ready_c0", 64'(multdiv_result_ready), 64'd0);
        next_cycle();
        for (int k = 1; k <= 32; k++) begin
            operand_A = $urandom;
            operand_B = $urandom;
            #3;
            check("stall_run", 64'(multdiv_stall), 64'd1);
            check("ready_run", 64'(multdiv_result_ready), 64'd0);
            next_cycle();
        end
        #3;
        check("stall_done", 64'(multdiv_stall), 64'd0);
        check("ready_done", 64'(multdiv_result_ready), 64'd1);
        check("result", 64'(multdiv_result), 64'(er));
        check("exception", 64'(multdiv_exception), 64'(ee));
        check("exc_code", 64'(multdiv_exception_code), 64'(ec));
        check("rd", 64'(multdiv_rd), 64'(rd));
        next_cycle();
        DX_Latch_Instr = NOP;
    endtask

    task automatic watch_idle(input string tag, input int n);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            #3;
            if (multdiv_result_ready !== 1'b0 || multdiv_stall !== 1'b0) seen++;
            next_cycle();
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        DX_flush = 1'b0;
        DX_Latch_Instr = NOP;
        operand_A = '0;
        operand_B = '0;
        next_cycle();
        next_cycle();
        #3;
        check("rst_stall", 64'(multdiv_stall), 64'd0);
        check("rst_ready", 64'(multdiv_result_ready), 64'd0);
        check("rst_result", 64'(multdiv_result), 64'd0);
        check("rst_exc", 64'(multdiv_exception), 64'd0);
        check("rst_code", 64'(multdiv_exception_code), 64'd0);
        check("rst_rd", 64'(multdiv_rd), 64'd0);
        reset = 1'b0;
        next_cycle();

        #3;
        check("nop_stall", 64'(multdiv_stall), 64'd0);
        next_cycle();

        run_op(1'b0, 32'd7, 32'hFFFF_FFFA, 5'd5);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd9);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd12);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(1'b1, 32'd5, 32'd0, 5'd21);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd3);

        // Reset in RUN with the counter at 10 (cycle 11).
        DX_Latch_Instr = mk(1'b0, 5'd7);
        operand_A = 32'd3;
        operand_B = 32'd4;
        next_cycle();
        for (int k = 1; k < 11; k++) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        DX_Latch_Instr = NOP;
        #3;
        check("rstrun_stall", 64'(multdiv_stall), 64'd0);
        next_cycle();
        watch_idle("rstrun_quiet", 30);
        run_op(1'b0, 32'hFFFF_FFFD, 32'd11, 5'd30);

        // Reset and start together: reset wins.
        reset = 1'b1;
        DX_Latch_Instr = mk(1'b1, 5'd4);
        #3;
        check("rststart_stall", 64'(multdiv_stall), 64'd0);
        next_cycle();
        reset = 1'b0;
        DX_Latch_Instr = NOP;
        #3;
        check("rststart_after", 64'(multdiv_stall), 64'd0);
        next_cycle();

        // Flush while IDLE with a mul in D/X.
        DX_Latch_Instr = mk(1'b0, 5'd8);
        DX_flush = 1'b1;
        #3;
        check("flush_idle_stall", 64'(multdiv_stall), 64'd0);
        next_cycle();
        DX_flush = 1'b0;
        DX_Latch_Instr = NOP;
        #3;
        check("flush_idle_nostart", 64'(multdiv_stall), 64'd0);
        next_cycle();

        // Flush during RUN.
        DX_Latch_Instr = mk(1'b1, 5'd10);
        operand_A = 32'd100;
        operand_B = 32'd7;
        next_cycle();
        for (int k = 1; k < 5; k++) next_cycle();
        DX_flush = 1'b1;
        next_cycle();
        DX_flush = 1'b0;
        DX_Latch_Instr = NOP;
        #3;
        check("flush_run_stall", 64'(multdiv_stall), 64'd0);
        check("flush_run_ready", 64'(multdiv_result_ready), 64'd0);
        next_cycle();
        watch_idle("flush_run_quiet", 40);

        // Randomized mul/div, including small values and zero divisors.
        for (int n = 0; n < 16; n++) begin
            logic [31:0] a, b;
            bit          d;
            d = bit'($urandom_range(1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(3))
                0: b = 32'd0;
                1: begin a = 32'($signed(16'($urandom))); b = 32'($signed(8'($urandom))); end
                default: ;
            endcase
            run_op(d, a, b, 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
